// File: rtl/datamem_pkg.sv
// datamem_pkg: shared types for the memory-stage access unit.
// FSM states, write-back select encodings, default ack timeout.
package datamem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  localparam int WAIT_MAX_DEF = 15;

endpackage

// File: rtl/datamem_access_unit_if.sv
// datamem_access_unit_if: req/ack data-memory bus.
// master drives req/we/addr/wdata; slave returns ack/rdata.
interface datamem_access_unit_if #(
  parameter int DATA_W = 64
) ();

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/datamem_timeout_counter.sv
// datamem_timeout_counter: 4-bit ack-wait counter.
// in: clk, reset_n, clr, en; out: tc (this enabled cycle is the MAX-th).
module datamem_timeout_counter #(
  parameter int MAX = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 4'd1;
    end
  end

  // cnt holds cycles already spent; this cycle makes cnt+1
  assign tc = en && (cnt == 4'(MAX - 1));

endmodule

// File: rtl/datamem_access_unit.sv
// datamem_access_unit: memory-stage req/ack controller with stall.
// in: ctl word, AluIn/StoreIn/LinkIn; out: Stall, WbData, Fwd*, Err, mem bus.
module datamem_access_unit
  import datamem_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ReadMem,
  input  logic              MemWr,
  input  logic              FwdMem,
  input  logic [1:0]        RegWData,
  input  logic [DATA_W-1:0] AluIn,
  input  logic [DATA_W-1:0] StoreIn,
  input  logic [DATA_W-1:0] LinkIn,
  datamem_access_unit_if.master mem,
  output logic              Stall,
  output logic [DATA_W-1:0] WbData,
  output logic [DATA_W-1:0] FwdData,
  output logic              FwdValid,
  output logic              Err
);

  state_t            state, state_nx;
  logic              req_nx, we_nx, err_nx;
  logic [DATA_W-1:0] addr_nx, wdata_nx;
  logic [DATA_W-1:0] rd_q, rd_nx;
  logic              cnt_clr, cnt_en, cnt_tc;
  logic              busy;

  datamem_timeout_counter #(
    .MAX(WAIT_MAX)
  ) u_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .tc     (cnt_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      rd_q          <= '0;
      Err           <= 1'b0;
    end else begin
      state         <= state_nx;
      mem.mem_req   <= req_nx;
      mem.mem_we    <= we_nx;
      mem.mem_addr  <= addr_nx;
      mem.mem_wdata <= wdata_nx;
      rd_q          <= rd_nx;
      Err           <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    req_nx   = mem.mem_req;
    we_nx    = mem.mem_we;
    addr_nx  = mem.mem_addr;
    wdata_nx = mem.mem_wdata;
    rd_nx    = rd_q;
    err_nx   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    busy     = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (ReadMem || MemWr) begin
          busy     = 1'b1;
          req_nx   = 1'b1;
          we_nx    = MemWr;
          addr_nx  = AluIn;
          wdata_nx = StoreIn;
          cnt_clr  = 1'b1;
          state_nx = WAIT;
        end
      end
      (state == WAIT): begin
        busy   = 1'b1;
        cnt_en = 1'b1;
        // ack beats a same-cycle timeout
        if (mem.mem_ack) begin
          req_nx   = 1'b0;
          state_nx = DONE;
          if (!mem.mem_we) begin
            rd_nx = mem.mem_rdata;
          end
        end else if (cnt_tc) begin
          req_nx   = 1'b0;
          rd_nx    = '0;
          err_nx   = 1'b1;
          state_nx = DONE;
        end
      end
      // queue still shows the finished op here: never reissue
      (state == DONE): begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    WbData = AluIn;
    unique case (RegWData)
      WB_MEM:  WbData = rd_q;
      WB_LINK: WbData = LinkIn;
      default: WbData = AluIn;
    endcase
  end

  // reset must mask the combinational IDLE request stall
  assign Stall    = reset_n && busy;
  assign FwdData  = WbData;
  assign FwdValid = reset_n && FwdMem && !Stall;

endmodule

// File: tb/tb_datamem_access_unit.sv
// tb_datamem_access_unit: directed bench with a memory-request scoreboard.
// Drives the control word, plays the memory slave, checks bus and outputs.
module tb_datamem_access_unit;

  typedef struct packed {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ReadMem, MemWr, FwdMem;
  logic [1:0]  RegWData;
  logic [63:0] AluIn, StoreIn, LinkIn;
  logic        Stall, FwdValid, Err;
  logic [63:0] WbData, FwdData;

  int   checks = 0;
  int   failures = 0;
  int   req_cnt = 0;
  logic req_d = 1'b0;
  txn_t sbq[$];

  datamem_access_unit_if #(.DATA_W(64)) mem_if ();

  datamem_access_unit #(
    .DATA_W  (64),
    .WAIT_MAX(15)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ReadMem (ReadMem),
    .MemWr   (MemWr),
    .FwdMem  (FwdMem),
    .RegWData(RegWData),
    .AluIn   (AluIn),
    .StoreIn (StoreIn),
    .LinkIn  (LinkIn),
    .mem     (mem_if.master),
    .Stall   (Stall),
    .WbData  (WbData),
    .FwdData (FwdData),
    .FwdValid(FwdValid),
    .Err     (Err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_if.mem_req && !req_d) req_cnt <= req_cnt + 1;
    req_d <= mem_if.mem_req;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_chk(input string tag, input logic [1:0] rwd,
                          input logic [63:0] alu, input logic [63:0] exp);
    @(posedge clk); #1;
    ReadMem = 0; MemWr = 0; FwdMem = 1;
    RegWData = rwd; AluIn = alu; mem_if.mem_ack = 0;
    @(negedge clk);
    chk({tag, " wb"}, WbData, exp);
    chk({tag, " fwd"}, FwdData, exp);
    chk({tag, " fv"}, FwdValid, 1);
    chk({tag, " stall"}, Stall, 0);
  endtask

  task automatic do_op(input string tag, input logic rm, input logic mw,
                       input logic [1:0] rwd, input logic [63:0] alu,
                       input logic [63:0] st, input logic [63:0] rd,
                       input int ack_at, input int exp_stall,
                       input logic [63:0] exp_wb, input logic exp_err,
                       input bit spur);
    int   stalls;
    int   r0;
    bit   done;
    txn_t t;
    @(posedge clk); #1;
    ReadMem = rm; MemWr = mw; RegWData = rwd;
    AluIn = alu; StoreIn = st; FwdMem = 1; mem_if.mem_ack = 0;
    sbq.push_back('{addr: alu, we: mw, wdata: st});
    r0 = req_cnt;
    @(negedge clk);
    chk({tag, " stall0"}, Stall, 1);
    chk({tag, " fv0"}, FwdValid, 0);
    stalls = 1;
    done = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      mem_if.mem_ack = 0;
      mem_if.mem_rdata = 64'hDEAD_0000;
      @(negedge clk);
      if (!Stall) begin
        done = 1;
        break;
      end
      stalls++;
      if (i == 1) begin
        chk({tag, " req"}, mem_if.mem_req, 1);
        chk({tag, " sb nonempty"}, sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          t = sbq.pop_front();
          chk({tag, " addr"}, mem_if.mem_addr, t.addr);
          chk({tag, " we"}, mem_if.mem_we, t.we);
          chk({tag, " wdata"}, mem_if.mem_wdata, t.wdata);
        end
      end
      if (i == ack_at) begin
        mem_if.mem_ack = 1;
        mem_if.mem_rdata = rd;
      end
    end
    chk({tag, " done"}, done, 1);
    chk({tag, " stalls"}, stalls, exp_stall);
    chk({tag, " wb"}, WbData, exp_wb);
    chk({tag, " fwd"}, FwdData, exp_wb);
    chk({tag, " fv"}, FwdValid, 1);
    chk({tag, " err"}, Err, exp_err);
    chk({tag, " req low"}, mem_if.mem_req, 0);
    chk({tag, " nreq"}, req_cnt - r0, 1);
    if (spur) begin
      mem_if.mem_ack = 1;
      mem_if.mem_rdata = 64'hBAD;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    txn_t t;
    reset_n = 0;
    ReadMem = 1; MemWr = 0; FwdMem = 1; RegWData = 2'd1;
    AluIn = 64'h99; StoreIn = 64'h0; LinkIn = 64'h1004;
    mem_if.mem_ack = 0; mem_if.mem_rdata = 64'h0;
    #12;
    chk("rst stall", Stall, 0);
    chk("rst fv", FwdValid, 0);
    chk("rst req", mem_if.mem_req, 0);
    chk("rst we", mem_if.mem_we, 0);
    chk("rst addr", mem_if.mem_addr, 0);
    chk("rst wdata", mem_if.mem_wdata, 0);
    chk("rst err", Err, 0);
    chk("rst rdreg", WbData, 0);
    ReadMem = 0;
    @(negedge clk);
    reset_n = 1;

    idle_chk("alu", 2'd0, 64'h10, 64'h10);
    idle_chk("link", 2'd2, 64'h10, 64'h1004);
    idle_chk("sel3", 2'd3, 64'h33, 64'h33);

    do_op("load", 1, 0, 2'd1, 64'h40, 64'h0, 64'hABCD,
          3, 4, 64'hABCD, 0, 0);
    idle_chk("last rd", 2'd1, 64'h1, 64'hABCD);

    do_op("store", 1, 1, 2'd0, 64'h80, 64'h55, 64'h7777,
          1, 2, 64'h80, 0, 0);
    idle_chk("rd kept", 2'd1, 64'h1, 64'hABCD);

    do_op("tmo", 1, 0, 2'd1, 64'hC0, 64'h0, 64'h0,
          0, 16, 64'h0, 1, 1);
    r0 = req_cnt;
    @(posedge clk); #1;
    mem_if.mem_ack = 0; ReadMem = 0; MemWr = 0; RegWData = 2'd1;
    @(negedge clk);
    chk("spur wb", WbData, 0);
    chk("spur err", Err, 0);
    chk("spur stall", Stall, 0);
    chk("spur req", mem_if.mem_req, 0);
    @(negedge clk);
    chk("spur nreq", req_cnt - r0, 0);

    do_op("ld1", 1, 0, 2'd1, 64'h100, 64'h0, 64'h11,
          1, 2, 64'h11, 0, 0);
    do_op("ld2", 1, 0, 2'd1, 64'h108, 64'h0, 64'h22,
          2, 3, 64'h22, 0, 0);
    r0 = req_cnt;
    @(posedge clk); #1;
    ReadMem = 0;
    @(negedge clk);
    chk("b2b idle", Stall, 0);

    @(posedge clk); #1;
    ReadMem = 1; MemWr = 0; AluIn = 64'h200; FwdMem = 1;
    sbq.push_back('{addr: 64'h200, we: 1'b0, wdata: StoreIn});
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid req", mem_if.mem_req, 1);
    chk("mid sb", sbq.size() != 0, 1);
    if (sbq.size() != 0) begin
      t = sbq.pop_front();
      chk("mid addr", mem_if.mem_addr, t.addr);
    end
    @(posedge clk); #1;
    reset_n = 0;
    #1;
    chk("mid rst req", mem_if.mem_req, 0);
    chk("mid rst stall", Stall, 0);
    chk("mid rst fv", FwdValid, 0);
    ReadMem = 0; RegWData = 2'd0; AluIn = 64'h77;
    #2;
    reset_n = 1;
    @(negedge clk);
    chk("post rst wb", WbData, 64'h77);
    chk("post rst stall", Stall, 0);
    @(negedge clk);
    chk("no reissue", mem_if.mem_req, 0);

    chk("sb drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
